// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard bus: read, writeback, issue and clear signals.
// Master is the pipeline (decode + writeback); slave is the register file.
interface regfile_scoreboard_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            wr_en;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            issue_en;
   logic [AW-1:0]   issue_rd;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            hazard;
   logic            clr_req;
   logic            clr_busy;

   modport master (
      output rs1_addr, rs2_addr, wr_en, rd_addr, rd_data,
             issue_en, issue_rd, clr_req,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy, hazard, clr_busy
   );

   modport slave (
      input  rs1_addr, rs2_addr, wr_en, rd_addr, rd_data,
             issue_en, issue_rd, clr_req,
      output rs1_data, rs2_data, rs1_busy, rs2_busy, hazard, clr_busy
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with busy scoreboard and multi-cycle clear; reads are zero-latency, writes land at posedge.
// No backpressure on inputs: hazard requests a pipeline stall, clear ignores writes/issues while busy.
module regfile_scoreboard #(
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input logic                 clk,
   input logic                 rst,
   regfile_scoreboard_if.slave bus
);
   localparam int NREG      = 1 << AW;
   localparam bit BYPASS_EN = (BYPASS != 0);
   localparam logic [AW-1:0] CNT_LAST = '1;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   cnt, cnt_nxt;
   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy, busy_nxt;

   logic idle, wr_ok, fwd1, fwd2, mask1, mask2;

   assign idle  = (state == IDLE);
   assign wr_ok = idle && bus.wr_en && (bus.rd_addr != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         busy  <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.clr_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = AW'(1);
            end
         end
         CLEAR: begin
            if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + AW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Issue is applied after writeback so a younger producer keeps the bit set.
   always_comb begin
      busy_nxt = busy;
      if (!idle) begin
         busy_nxt[cnt] = 1'b0;
      end else begin
         if (bus.wr_en)
            busy_nxt[bus.rd_addr] = 1'b0;
         if (bus.issue_en)
            busy_nxt[bus.issue_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (!idle) begin
         regs[cnt] <= '0;
      end else if (wr_ok) begin
         regs[bus.rd_addr] <= bus.rd_data;
      end
   end

   assign fwd1  = BYPASS_EN && wr_ok && (bus.rd_addr == bus.rs1_addr);
   assign fwd2  = BYPASS_EN && wr_ok && (bus.rd_addr == bus.rs2_addr);
   assign mask1 = BYPASS_EN && idle && bus.wr_en && (bus.rd_addr == bus.rs1_addr);
   assign mask2 = BYPASS_EN && idle && bus.wr_en && (bus.rd_addr == bus.rs2_addr);

   assign bus.rs1_data = (bus.rs1_addr == '0) ? '0 :
                         fwd1 ? bus.rd_data : regs[bus.rs1_addr];
   assign bus.rs2_data = (bus.rs2_addr == '0) ? '0 :
                         fwd2 ? bus.rd_data : regs[bus.rs2_addr];

   // busy[0] is held at 0, so address 0 never reports busy.
   assign bus.rs1_busy = busy[bus.rs1_addr] && !mask1;
   assign bus.rs2_busy = busy[bus.rs2_addr] && !mask2;
   assign bus.clr_busy = !idle;
   assign bus.hazard   = bus.rs1_busy || bus.rs2_busy || !idle;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: bypass and no-bypass instances share stimulus; a queue-based scoreboard checks both
// against an array/queue model of the register file rules.
module tb_regfile_scoreboard;
   localparam int XLEN = 32;
   localparam int AW   = 5;
   localparam int NREG = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus_a ();
   regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW)) bus_b ();

   assign bus_b.rs1_addr = bus_a.rs1_addr;
   assign bus_b.rs2_addr = bus_a.rs2_addr;
   assign bus_b.wr_en    = bus_a.wr_en;
   assign bus_b.rd_addr  = bus_a.rd_addr;
   assign bus_b.rd_data  = bus_a.rd_data;
   assign bus_b.issue_en = bus_a.issue_en;
   assign bus_b.issue_rd = bus_a.issue_rd;
   assign bus_b.clr_req  = bus_a.clr_req;

   regfile_scoreboard #(.XLEN(XLEN), .AW(AW), .BYPASS(1)) dut_byp (
      .clk(clk), .rst(rst), .bus(bus_a));
   regfile_scoreboard #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) dut_nob (
      .clk(clk), .rst(rst), .bus(bus_b));

   typedef struct {
      logic [XLEN-1:0] d1, d2, nd1, nd2;
      logic            b1, b2, hz, cb, nb1, nb2, nhz;
   } exp_t;

   exp_t exp_q [$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   cb_cnt  = 0;

   logic [XLEN-1:0] m_regs [NREG];
   bit              m_busy [NREG];
   int              clr_q  [$];   // registers still to be zeroed by the clear

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   task automatic chk_b(input string name, input logic act, input logic req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %b, expected %b", name, act, req);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      clr_q.delete();
   endtask

   function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && clr_q.size() == 0 && bus_a.wr_en && bus_a.rd_addr != 0 && bus_a.rd_addr == a)
         return bus_a.rd_data;
      return m_regs[a];
   endfunction

   function automatic logic m_bsy(input logic [AW-1:0] a, input bit byp);
      if (a == 0 || !m_busy[a]) return 1'b0;
      if (byp && clr_q.size() == 0 && bus_a.wr_en && bus_a.rd_addr == a) return 1'b0;
      return 1'b1;
   endfunction

   function automatic exp_t model_expect();
      exp_t e;
      e.d1  = m_read(bus_a.rs1_addr, 1'b1);
      e.d2  = m_read(bus_a.rs2_addr, 1'b1);
      e.nd1 = m_read(bus_a.rs1_addr, 1'b0);
      e.nd2 = m_read(bus_a.rs2_addr, 1'b0);
      e.b1  = m_bsy(bus_a.rs1_addr, 1'b1);
      e.b2  = m_bsy(bus_a.rs2_addr, 1'b1);
      e.nb1 = m_bsy(bus_a.rs1_addr, 1'b0);
      e.nb2 = m_bsy(bus_a.rs2_addr, 1'b0);
      e.cb  = (clr_q.size() != 0);
      e.hz  = e.b1 | e.b2 | e.cb;
      e.nhz = e.nb1 | e.nb2 | e.cb;
      return e;
   endfunction

   task automatic model_update();
      if (clr_q.size() != 0) begin
         int idx = clr_q.pop_front();
         m_regs[idx] = '0;
         m_busy[idx] = 1'b0;
      end else begin
         if (bus_a.wr_en && bus_a.rd_addr != 0) m_regs[bus_a.rd_addr] = bus_a.rd_data;
         if (bus_a.wr_en) m_busy[bus_a.rd_addr] = 1'b0;
         if (bus_a.issue_en && bus_a.issue_rd != 0) m_busy[bus_a.issue_rd] = 1'b1;
         if (bus_a.clr_req)
            for (int i = 1; i < NREG; i++) clr_q.push_back(i);
      end
   endtask

   task automatic step(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic we, input logic [AW-1:0] rd, input logic [XLEN-1:0] wd,
                       input logic ie, input logic [AW-1:0] ir, input logic cr);
      @(posedge clk);
      #1;
      bus_a.rs1_addr = a1;
      bus_a.rs2_addr = a2;
      bus_a.wr_en    = we;
      bus_a.rd_addr  = rd;
      bus_a.rd_data  = wd;
      bus_a.issue_en = ie;
      bus_a.issue_rd = ir;
      bus_a.clr_req  = cr;
      exp_q.push_back(model_expect());
      model_update();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && bus_a.clr_busy) cb_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk  ("byp_rs1_data",  bus_a.rs1_data, e.d1);
         chk  ("byp_rs2_data",  bus_a.rs2_data, e.d2);
         chk_b("byp_rs1_busy",  bus_a.rs1_busy, e.b1);
         chk_b("byp_rs2_busy",  bus_a.rs2_busy, e.b2);
         chk_b("byp_hazard",    bus_a.hazard,   e.hz);
         chk_b("byp_clr_busy",  bus_a.clr_busy, e.cb);
         chk  ("nob_rs1_data",  bus_b.rs1_data, e.nd1);
         chk  ("nob_rs2_data",  bus_b.rs2_data, e.nd2);
         chk_b("nob_rs1_busy",  bus_b.rs1_busy, e.nb1);
         chk_b("nob_rs2_busy",  bus_b.rs2_busy, e.nb2);
         chk_b("nob_hazard",    bus_b.hazard,   e.nhz);
         chk_b("nob_clr_busy",  bus_b.clr_busy, e.cb);
      end
   end

   initial begin
      logic [AW-1:0]   r1, r2, rd, ir;
      logic [XLEN-1:0] wd;

      bus_a.rs1_addr = 5'd5;
      bus_a.rs2_addr = 5'd7;
      bus_a.wr_en    = 1'b0;
      bus_a.rd_addr  = '0;
      bus_a.rd_data  = '0;
      bus_a.issue_en = 1'b0;
      bus_a.issue_rd = '0;
      bus_a.clr_req  = 1'b0;
      model_reset();

      #3;
      chk  ("reset_rs1_data", bus_a.rs1_data, '0);
      chk  ("reset_rs2_data", bus_a.rs2_data, '0);
      chk_b("reset_rs1_busy", bus_a.rs1_busy, 1'b0);
      chk_b("reset_hazard",   bus_a.hazard,   1'b0);
      chk_b("reset_clr_busy", bus_a.clr_busy, 1'b0);
      #10 rst = 1'b1;

      // write / read / x0
      step(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
      step(5'd5, 5'd0, 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 1'b0);
      step(5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0);
      // bypass
      step(5'd7, 5'd5, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
      step(5'd7, 5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0);
      // scoreboard set / clear
      step(5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b0);
      step(5'd0, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0);
      step(5'd0, 5'd3, 1'b1, 5'd3, 32'h33333333, 1'b0, 5'd0, 1'b0);
      step(5'd0, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0);
      // same-cycle set and clear
      step(5'd9, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0);
      step(5'd9, 5'd0, 1'b1, 5'd9, 32'h99999999, 1'b1, 5'd9, 1'b0);
      step(5'd9, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0);
      // clear sequence
      step(5'd0, 5'd0, 1'b1, 5'd1,  32'h00000001, 1'b0, 5'd0, 1'b0);
      step(5'd0, 5'd0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd4, 1'b0);
      cb_cnt = 0;
      step(5'd4, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
      for (int i = 0; i < NREG - 1; i++)
         step(5'd1, 5'd31, (i == 4), 5'd2, 32'h22222222, (i == 6), 5'd6, (i == 8));
      step(5'd4, 5'd2,  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      step(5'd1, 5'd31, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      #1 chk("clear_cycles", XLEN'(cb_cnt), XLEN'(NREG - 1));

      // async reset in the middle of a clear
      step(5'd0, 5'd0, 1'b1, 5'd5,  32'h55555555, 1'b0, 5'd0, 1'b0);
      step(5'd0, 5'd0, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd20, 1'b0);
      step(5'd0, 5'd0, 1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 1'b1);
      for (int i = 0; i < 10; i++)
         step(5'd31, 5'd20, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      @(negedge clk);
      #2;
      bus_a.wr_en    = 1'b0;
      bus_a.issue_en = 1'b0;
      bus_a.clr_req  = 1'b0;
      bus_a.rs2_addr = 5'd5;
      rst = 1'b0;
      #1;
      chk_b("arst_clr_busy", bus_a.clr_busy, 1'b0);
      chk_b("arst_hazard",   bus_a.hazard,   1'b0);
      chk  ("arst_rs1_data", bus_a.rs1_data, '0);
      chk  ("arst_rs2_data", bus_a.rs2_data, '0);
      chk  ("arst_nob_rs1",  bus_b.rs1_data, '0);
      model_reset();
      #1 rst = 1'b1;

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         r1 = AW'($urandom_range(0, NREG - 1));
         r2 = AW'($urandom_range(0, NREG - 1));
         rd = ($urandom_range(0, 3) == 0) ? r1 : AW'($urandom_range(0, NREG - 1));
         ir = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NREG - 1));
         wd = $urandom;
         step(r1, r2, 1'($urandom_range(0, 1)), rd, wd, 1'($urandom_range(0, 1)), ir,
              ($urandom_range(0, 63) == 0));
      end

      for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
      #1 chk("queue_drained", XLEN'(exp_q.size()), '0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
